// File: rtl/seg_pkg.sv
// seg_pkg: flash FSM state type and seven-segment patterns ({g,f,e,d,c,b,a}, active-low)
package seg_pkg;
  typedef enum logic [1:0] {IDLE, DARK, LIT} flash_state_e;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD to seven-segment decoder, dash for 10..15
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = (bcd > 4'd9) ? SEG_DASH : SEG_DIGITS[bcd];
endmodule

// File: rtl/seg_scan2.sv
// seg_scan2: two-digit multiplexed display driver with carry-triggered flash
module seg_scan2
  import seg_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_DIV   = 12500000,
  parameter int BLINK_COUNT = 3,
  parameter int LZB         = 1
) (
  input  logic       C_CLK,
  input  logic       RST,
  input  logic [3:0] D_OUT1,
  input  logic [3:0] D_OUT0,
  input  logic       C_out,
  output logic [1:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       FLASH
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int CW = $clog2(BLINK_COUNT + 1);
  logic [SW-1:0] scan_q;
  logic [BW-1:0] ph_q;
  logic [CW-1:0] dark_q;
  logic [3:0] tens_q, units_q;
  logic sel_q, live_q, c_d_q, flash_q;
  logic [1:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, dec_seg;
  flash_state_e state_q;
  logic wrap, rise, ph_end, blank_tens;
  assign wrap       = scan_q == SW'(SCAN_DIV - 1);
  assign ph_end     = ph_q == BW'(BLINK_DIV - 1);
  assign rise       = C_out & ~c_d_q;
  assign blank_tens = (LZB != 0) && sel_q && (tens_q == 4'd0);
  bcd_to_seg u_dec (.bcd(sel_q ? tens_q : units_q), .seg(dec_seg));
  // live_q keeps the display dark from reset release until the first slot is sampled
  always_comb begin
    an_d  = (!live_q || blank_tens || state_q == DARK) ? 2'b11 : (sel_q ? 2'b01 : 2'b10);
    seg_d = (!live_q || blank_tens) ? SEG_BLANK : dec_seg;
  end
  always_ff @(posedge C_CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ph_q    <= '0;
      dark_q  <= '0;
      c_d_q   <= 1'b0;
    end else begin
      c_d_q <= C_out;
      if (rise) begin
        state_q <= DARK;
        ph_q    <= '0;
        dark_q  <= CW'(BLINK_COUNT);
      end else if (state_q != IDLE) begin
        ph_q <= ph_end ? '0 : ph_q + 1'b1;
        if (ph_end) begin
          if (state_q == DARK) dark_q <= dark_q - 1'b1;
          state_q <= (state_q == LIT) ? DARK : ((dark_q != CW'(1)) ? LIT : IDLE);
        end
      end
    end
  end
  always_ff @(posedge C_CLK) begin
    if (RST) begin
      scan_q  <= '0;
      sel_q   <= 1'b0;
      live_q  <= 1'b0;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      an_q    <= 2'b11;
      seg_q   <= SEG_BLANK;
      flash_q <= 1'b0;
    end else begin
      scan_q <= wrap ? '0 : scan_q + 1'b1;
      if (wrap) begin
        sel_q   <= ~sel_q;
        live_q  <= 1'b1;
        tens_q  <= D_OUT1;
        units_q <= D_OUT0;
      end
      an_q    <= an_d;
      seg_q   <= seg_d;
      flash_q <= state_q != IDLE;
    end
  end
  assign AN    = an_q;
  assign SEG   = seg_q;
  assign DP    = 1'b1;
  assign FLASH = flash_q;
endmodule

// File: tb/tb_seg_scan2.sv
// tb_seg_scan2: randomized scoreboard bench; expected display derived from cycle arithmetic
module tb_seg_scan2;
  localparam int SD = 4, BD = 8, BC = 2, LZ = 1;
  typedef struct packed {logic [1:0] an; logic [6:0] seg; logic fl;} exp_t;
  logic clk = 1'b0, rst = 1'b1, c_out = 1'b1;
  logic [3:0] d1 = 4'd0, d0 = 4'd0;
  logic [1:0] an;
  logic [6:0] seg;
  logic dp, fl;
  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0;
  int t = 0;
  seg_scan2 #(.SCAN_DIV(SD), .BLINK_DIV(BD), .BLINK_COUNT(BC), .LZB(LZ)) dut (
    .C_CLK(clk), .RST(rst), .D_OUT1(d1), .D_OUT0(d0), .C_out(c_out),
    .AN(an), .SEG(seg), .DP(dp), .FLASH(fl)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask
  // Reference: t counts edges since reset release; slot k=(t-1)/SD, flash age d=(t-1)-rise edge
  initial begin
    int r, k, d;
    bit prevc, started, live, sel, flash, dark, blank_t;
    logic [3:0] h1, h0;
    exp_t e;
    r = -100000; prevc = 0; started = 0; h1 = 0; h0 = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        started = 1; t = 0; r = -100000; prevc = 0; h1 = 0; h0 = 0;
        exp_q.push_back({2'b11, 7'b1111111, 1'b0});
      end else if (started) begin
        t++;
        k = (t - 1) / SD;
        live = k >= 1;
        sel = k[0];
        d = t - 1 - r;
        flash = d >= 0 && d < BD * (2 * BC - 1);
        dark = flash && ((d / BD) % 2 == 0);
        blank_t = LZ != 0 && sel && h1 == 4'd0;
        e.an = (!live || blank_t || dark) ? 2'b11 : (sel ? 2'b01 : 2'b10);
        e.seg = (!live || blank_t) ? 7'b1111111 : ref_seg(sel ? h1 : h0);
        e.fl = flash;
        exp_q.push_back(e);
        if (c_out && !prevc) r = t;
        prevc = c_out;
        if (t % SD == 0) begin h1 = d1; h0 = d0; end
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("AN", int'(an), int'(e.an));
        chk("SEG", int'(seg), int'(e.seg));
        chk("FLASH", int'(fl), int'(e.fl));
        chk("DP", int'(dp), 1);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse();
    c_out = 1'b1; step(1); c_out = 1'b0;
  endtask
  initial begin
    step(3);
    rst = 1'b0; c_out = 1'b0; d1 = 4'd5; d0 = 4'd3;
    step(24);
    d1 = 4'd0; d0 = 4'd7;
    step(9);
    for (int i = 0; i < 8 && t % SD != 1; i++) step(1);
    d0 = 4'd8;
    step(12);
    d1 = 4'hC; d0 = 4'd1;
    step(16);
    d1 = 4'd4; d0 = 4'd2;
    pulse(); step(30);
    pulse(); step(11); pulse(); step(30);
    pulse(); step(4); rst = 1'b1; step(1); rst = 1'b0; step(20);
    for (int i = 0; i < 600; i++) begin
      d1 = 4'($urandom_range(0, 15));
      d0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) c_out = ~c_out;
      rst = $urandom_range(0, 199) == 0;
      step($urandom_range(1, 5));
    end
    rst = 1'b0; c_out = 1'b0;
    step(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
